// File: rtl/pic_pkg.sv
// Shared definitions for the 5x7 picture path: geometry, editor state
// encoding and the row/column to bitmap-index mapping used by both sides.
package pic_pkg;

  localparam int ROWS = 5;
  localparam int COLS = 7;
  localparam int PIX  = 35;

  typedef enum logic {
    VIEW = 1'b0,
    EDIT = 1'b1
  } state_t;

  function automatic logic [5:0] pix_index(input logic [2:0] row, input logic [2:0] col);
    return ({3'b000, row} * 6'd7) + {3'b000, col};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces one raw active-low push-button and emits a single-cycle pulse
// per accepted press. Releases are debounced but produce no pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          stable_d_r;
  logic [CW-1:0] cnt_r;

  // Synchronise, qualify the level for a full stable window, then edge-detect.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      stable_r   <= 1'b1;
      stable_d_r <= 1'b1;
      cnt_r      <= '0;
      press      <= 1'b0;
    end else begin
      sync1_r    <= key_n;
      sync2_r    <= sync1_r;
      stable_d_r <= stable_r;
      // The pulse trails the stable level by one cycle on purpose.
      press      <= stable_d_r & ~stable_r;
      if (sync2_r == stable_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_r <= sync2_r;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pic_editor.sv
// Button-driven picture editor: debounces five keys and maintains the
// edit-mode flag, wrap-around cursor and 35-pixel bitmap for the display.
module pic_editor
  import pic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic          CLOCK_50,
  input  logic          rst_n,
  input  logic          en,
  input  logic          key_mode,
  input  logic          key_move_r,
  input  logic          key_move_d,
  input  logic          key_toggle,
  input  logic          key_clear,
  output logic          edit,
  output logic [PIX-1:0] ens_storage,
  output logic [PIX-1:0] ens_cursor,
  output logic [2:0]    cursor_row,
  output logic [2:0]    cursor_col
);

  logic   [4:0]     key_n_s;
  logic   [4:0]     press_s;
  state_t           state_r;
  logic   [2:0]     row_inc_s;
  logic   [2:0]     col_inc_s;
  logic   [PIX-1:0] here_mask_s;
  logic   [PIX-1:0] down_mask_s;
  logic   [PIX-1:0] right_mask_s;

  // Bit order sets the priority: mode, clear, toggle, move_d, move_r.
  assign key_n_s = {key_mode, key_clear, key_toggle, key_move_d, key_move_r};

  for (genvar k = 0; k < 5; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .CLOCK_50 (CLOCK_50),
      .rst_n    (rst_n),
      .key_n    (key_n_s[k]),
      .press    (press_s[k])
    );
  end

  // Wrapped neighbour positions and their one-hot masks.
  always_comb begin
    row_inc_s    = (cursor_row == 3'd4) ? 3'd0 : cursor_row + 3'd1;
    col_inc_s    = (cursor_col == 3'd6) ? 3'd0 : cursor_col + 3'd1;
    here_mask_s  = 35'd1 << pix_index(cursor_row, cursor_col);
    down_mask_s  = 35'd1 << pix_index(row_inc_s, cursor_col);
    right_mask_s = 35'd1 << pix_index(cursor_row, col_inc_s);
  end

  assign edit = (state_r == EDIT);

  // Mode FSM with cursor and bitmap updates; one action per cycle at most.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_r     <= VIEW;
      ens_storage <= 35'd0;
      ens_cursor  <= 35'd1;
      cursor_row  <= 3'd0;
      cursor_col  <= 3'd0;
    end else if (en) begin
      case (state_r)
        VIEW: begin
          if (press_s[4]) state_r <= EDIT;
        end
        EDIT: begin
          if (press_s[4]) begin
            state_r <= VIEW;
          end else if (press_s[3]) begin
            ens_storage <= 35'd0;
          end else if (press_s[2]) begin
            ens_storage <= ens_storage ^ here_mask_s;
          end else if (press_s[1]) begin
            cursor_row <= row_inc_s;
            ens_cursor <= down_mask_s;
          end else if (press_s[0]) begin
            cursor_col <= col_inc_s;
            ens_cursor <= right_mask_s;
          end
        end
        default: state_r <= VIEW;
      endcase
    end
  end

endmodule

// File: doc/pic_editor.md
Name: pic_editor

Overview:
- Upstream stage of the 5x7 LED picture display path.
- Takes five raw active-low push-buttons and turns them into three display inputs:
  - a 35-bit picture bitmap (ens_storage);
  - a one-hot cursor mask (ens_cursor);
  - an edit-mode flag (edit).
- The downstream display/scan stage consumes all three directly.
- Owns debouncing, cursor movement with wrap-around, pixel toggling and mode control.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable CLOCK_50 cycles required before a key level is accepted (20 ms at 50 MHz).
- ROWS, 5: matrix rows. Fixed; the design is only required to work at 5.
- COLS, 7: matrix columns. Fixed; the design is only required to work at 7.

Ports:
- CLOCK_50  in  1   sole clock, 50 MHz
- rst_n  in  1   synchronous active-low reset, sampled on the CLOCK_50 rising edge
- en  in  1   block enable; when low, key events are discarded
- key_mode  in  1   raw button, active-low: enter/leave edit mode
- key_move_r  in  1   raw button, active-low: cursor one column right
- key_move_d  in  1   raw button, active-low: cursor one row down
- key_toggle  in  1   raw button, active-low: invert pixel under cursor
- key_clear  in  1   raw button, active-low: clear whole picture
- edit  out  1   1 = EDIT state
- ens_storage  out  35  picture bitmap; bit index = row*7 + col
- ens_cursor  out  35  one-hot cursor mask, same indexing
- cursor_row  out  3   current row, 0..4
- cursor_col  out  3   current column, 0..6

Behaviour:
- One clock (CLOCK_50); reset is synchronous and active-low (rst_n). All outputs are registered.
- Reset values:
  - edit=0
  - ens_storage=0
  - cursor_row=0, cursor_col=0
  - ens_cursor=35'h1
  - all debounce state = released (stable level 1, counters 0)
  - FSM = VIEW
- Reset asserted mid-debounce or mid-edit returns everything to these values on the next edge.
- Key conditioning, per key:
  - 2-flop synchroniser.
  - Counter increments while the synchronised level differs from the stable level; it clears whenever the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level updates and the counter clears.
  - A one-cycle press pulse fires in the cycle after the stable level goes 1->0.
  - Release generates nothing. Holding a key gives exactly one pulse (no auto-repeat).
- Latency: the output changes on the edge after the press pulse. Raw falling edge to output change = DEBOUNCE_CYCLES+4 cycles.
- Enable: when en=0, press pulses are discarded; FSM and outputs hold. Debouncers keep running, so a key held across en rising does not fire.
- FSM, 2 states:
  - VIEW: mode pulse -> EDIT; every other pulse is ignored.
  - EDIT:
    - mode pulse -> VIEW.
    - move_r: col = (col==6) ? 0 : col+1. Row is unchanged; there is no carry into the row.
    - move_d: row = (row==4) ? 0 : row+1.
    - toggle: ens_storage[row*7+col] ^= 1.
    - clear: ens_storage = 0; cursor unchanged.
  - Cursor position is retained across VIEW/EDIT transitions. ens_storage is retained in both states.
- Simultaneous pulses in one cycle: exactly one action executes, by priority mode > clear > toggle > move_d > move_r. Lower-priority pulses in that cycle are dropped.
- ens_cursor is always exactly one-hot, equal to 1 << (cursor_row*7 + cursor_col), and is updated in the same edge as cursor_row/cursor_col.
- Index arithmetic: row*7+col is computed at 6 bits; the maximum is 34.

Decomposition:
- Shared package pic_pkg:
  - ROWS=5, COLS=7, PIX=35;
  - state encoding VIEW=1'b0, EDIT=1'b1;
  - an index function (row, col) -> 6-bit bit index, reused by the display side.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES; ports CLOCK_50, rst_n, key_n, press), instantiated 5 times.
- FSM, cursor and bitmap registers stay in pic_editor.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset + mode press:
  - After reset: edit=0, ens_storage=0, ens_cursor=35'h1.
  - Hold key_mode low for 20 cycles -> edit=1 exactly 8 cycles after the falling edge, and a single transition only.
  - Glitch key_mode low for 3 cycles -> no change.
- Wrap-around:
  - In EDIT, 7 move_r presses -> cursor_col goes 1..6, then 0; cursor_row stays 0.
  - 5 move_d presses -> row goes 1..4, then 0.
  - At (4,6), ens_cursor = 35'h4_0000_0000 (bit 34).
- Toggle/clear:
  - At (2,3), toggle -> ens_storage bit 17 = 1. Toggle again -> 0.
  - Set bits 0 and 34, then clear -> ens_storage=0; cursor unchanged.
- VIEW lockout and en=0:
  - In VIEW, toggle and moves -> outputs unchanged.
  - In EDIT with en=0, mode/toggle presses -> no change.
  - Raise en while toggle is still held -> no toggle.
- Priority:
  - Force mode and toggle pulses in the same cycle (keys released together) -> only edit flips; ens_storage unchanged.
  - Toggle + move_r in the same cycle -> pixel toggles at the old position; cursor unchanged.
- Reset mid-operation:
  - Assert rst_n=0 for one edge while in EDIT at (3,5) with ens_storage nonzero -> all reset values on the next edge.
